// File: rtl/fifo2axi_resp_pkg.sv
// Shared definitions for the response-FIFO-to-AXI drain stage.
// - AXI response encodings.
// - Bit positions of the is_write and flag fields inside an id_resp entry,
//   expressed as functions of the AXI id width.
package fifo2axi_resp_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  // id_resp layout: {is_write, flag, id[ID-1:0]}
  function automatic int unsigned IS_WR_BIT(input int unsigned id_width);
    return id_width + 1;
  endfunction

  function automatic int unsigned FLAG_BIT(input int unsigned id_width);
    return id_width;
  endfunction

endpackage

// File: rtl/fifo2axi_resp_dual_sat_counter.sv
// Saturating event counter with synchronous clear.
// Ports:
//   aclk, aresetn : clock, synchronous active-low reset
//   inc           : count one event this cycle
//   clr           : clear to zero; wins over inc
//   value         : current count, sticks at all-ones
module sat_counter #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 inc,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] value
);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc && (value != '1)) begin
      value <= value + 1'b1;
    end
  end

endmodule

// File: rtl/fifo2axi_resp_dual.sv
// Drains the tagged response FIFOs (rdata, resp, id_resp popped in lockstep)
// onto independent AXI B and R output registers.
// Ports:
//   aclk, aresetn          : clock, synchronous active-low reset
//   *_r_en                 : pop strobes, all equal, combinational
//   axi_rdata/axi_resp/
//   axi_id_resp, *_empty   : FIFO heads and empty flags
//   bid/bresp/bvalid/bready: AXI B channel
//   rid/rdata/rresp/rlast/
//   rvalid/rready          : AXI R channel
//   stat_clr               : synchronous clear of statistics counters
//   b_cnt/r_beat_cnt/
//   drop_cnt               : saturating statistics
module fifo2axi_resp_dual
  import fifo2axi_resp_pkg::*;
#(
  parameter int unsigned AXI_ID_WIDTH = 8,
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  output logic                    rdata_r_en,
  input  logic [DATA_WIDTH-1:0]   axi_rdata,
  input  logic                    rdata_fifo_empty,
  output logic                    resp_r_en,
  input  logic [1:0]              axi_resp,
  input  logic                    resp_fifo_empty,
  output logic                    id_resp_r_en,
  input  logic [AXI_ID_WIDTH+1:0] axi_id_resp,
  input  logic                    id_resp_fifo_empty,
  output logic [AXI_ID_WIDTH-1:0] bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  output logic [AXI_ID_WIDTH-1:0] rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready,
  input  logic                    stat_clr,
  output logic [CNT_WIDTH-1:0]    b_cnt,
  output logic [CNT_WIDTH-1:0]    r_beat_cnt,
  output logic [CNT_WIDTH-1:0]    drop_cnt
);

  logic                    head_ok;
  logic                    is_write;
  logic                    flag;
  logic [AXI_ID_WIDTH-1:0] head_id;
  logic                    b_free;
  logic                    r_free;
  logic                    pop;
  logic                    b_load;
  logic                    r_load;
  logic                    drop;

  assign head_ok  = ~rdata_fifo_empty & ~resp_fifo_empty & ~id_resp_fifo_empty;
  assign is_write = axi_id_resp[IS_WR_BIT(AXI_ID_WIDTH)];
  assign flag     = axi_id_resp[FLAG_BIT(AXI_ID_WIDTH)];
  assign head_id  = axi_id_resp[AXI_ID_WIDTH-1:0];

  assign b_free = ~bvalid | bready;
  assign r_free = ~rvalid | rready;

  // Strictly in-order: only the head's own channel can stall it. Suppressed
  // writes never touch B, so they drain regardless of B backpressure.
  // Gated by aresetn so no entry is lost while the registers are held in reset.
  assign pop = aresetn & head_ok & (is_write ? (b_free | ~flag) : r_free);

  assign rdata_r_en   = pop;
  assign resp_r_en    = pop;
  assign id_resp_r_en = pop;

  assign b_load = pop & is_write & flag;
  assign drop   = pop & is_write & ~flag;
  assign r_load = pop & ~is_write;

  // B channel register. A load only happens when b_free, so the AXI hold
  // case (valid & ~ready) simply falls through and keeps every field.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      bid    <= '0;
      bresp  <= '0;
      bvalid <= 1'b0;
    end else if (b_load) begin
      bid    <= head_id;
      bresp  <= axi_resp;
      bvalid <= 1'b1;
    end else if (bvalid && bready) begin
      bid    <= '0;
      bresp  <= '0;
      bvalid <= 1'b0;
    end
  end

  // R channel register, same rule as B.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rid    <= '0;
      rdata  <= '0;
      rresp  <= '0;
      rlast  <= 1'b0;
      rvalid <= 1'b0;
    end else if (r_load) begin
      rid    <= head_id;
      rdata  <= axi_rdata;
      rresp  <= axi_resp;
      rlast  <= flag;
      rvalid <= 1'b1;
    end else if (rvalid && rready) begin
      rid    <= '0;
      rdata  <= '0;
      rresp  <= '0;
      rlast  <= 1'b0;
      rvalid <= 1'b0;
    end
  end

  sat_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_b_cnt (
    .aclk   (aclk),
    .aresetn(aresetn),
    .inc    (bvalid & bready),
    .clr    (stat_clr),
    .value  (b_cnt)
  );

  sat_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_r_beat_cnt (
    .aclk   (aclk),
    .aresetn(aresetn),
    .inc    (rvalid & rready),
    .clr    (stat_clr),
    .value  (r_beat_cnt)
  );

  sat_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_drop_cnt (
    .aclk   (aclk),
    .aresetn(aresetn),
    .inc    (drop),
    .clr    (stat_clr),
    .value  (drop_cnt)
  );

endmodule

// File: tb/tb_fifo2axi_resp_dual.sv
module tb_fifo2axi_resp_dual;

  localparam int unsigned IdW  = 8;
  localparam int unsigned DatW = 64;
  localparam int unsigned CntW = 4;

  logic            aclk;
  logic            aresetn;
  logic            rdata_r_en;
  logic [DatW-1:0] axi_rdata;
  logic            rdata_fifo_empty;
  logic            resp_r_en;
  logic [1:0]      axi_resp;
  logic            resp_fifo_empty;
  logic            id_resp_r_en;
  logic [IdW+1:0]  axi_id_resp;
  logic            id_resp_fifo_empty;
  logic [IdW-1:0]  bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic [IdW-1:0]  rid;
  logic [DatW-1:0] rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;
  logic            stat_clr;
  logic [CntW-1:0] b_cnt;
  logic [CntW-1:0] r_beat_cnt;
  logic [CntW-1:0] drop_cnt;

  fifo2axi_resp_dual #(
    .AXI_ID_WIDTH(IdW),
    .DATA_WIDTH  (DatW),
    .CNT_WIDTH   (CntW)
  ) dut (
    .aclk              (aclk),
    .aresetn           (aresetn),
    .rdata_r_en        (rdata_r_en),
    .axi_rdata         (axi_rdata),
    .rdata_fifo_empty  (rdata_fifo_empty),
    .resp_r_en         (resp_r_en),
    .axi_resp          (axi_resp),
    .resp_fifo_empty   (resp_fifo_empty),
    .id_resp_r_en      (id_resp_r_en),
    .axi_id_resp       (axi_id_resp),
    .id_resp_fifo_empty(id_resp_fifo_empty),
    .bid               (bid),
    .bresp             (bresp),
    .bvalid            (bvalid),
    .bready            (bready),
    .rid               (rid),
    .rdata             (rdata),
    .rresp             (rresp),
    .rlast             (rlast),
    .rvalid            (rvalid),
    .rready            (rready),
    .stat_clr          (stat_clr),
    .b_cnt             (b_cnt),
    .r_beat_cnt        (r_beat_cnt),
    .drop_cnt          (drop_cnt)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Stimulus FIFO feeding all three heads in lockstep.
  logic [DatW-1:0] mem_data [64];
  logic [1:0]      mem_resp [64];
  logic [IdW+1:0]  mem_idr  [64];
  int              wr_ptr = 0;
  int              rd_ptr = 0;
  int              pop_cnt = 0;

  wire fifo_empty = (wr_ptr == rd_ptr);
  assign rdata_fifo_empty   = fifo_empty;
  assign resp_fifo_empty    = fifo_empty;
  assign id_resp_fifo_empty = fifo_empty;
  assign axi_rdata   = mem_data[rd_ptr[5:0]];
  assign axi_resp    = mem_resp[rd_ptr[5:0]];
  assign axi_id_resp = mem_idr[rd_ptr[5:0]];

  always @(posedge aclk) begin
    if (rdata_r_en && !fifo_empty) begin
      rd_ptr  <= rd_ptr + 1;
      pop_cnt <= pop_cnt + 1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic is_wr, input logic flag, input logic [IdW-1:0] id,
                      input logic [1:0] resp, input logic [DatW-1:0] data);
    mem_data[wr_ptr[5:0]] = data;
    mem_resp[wr_ptr[5:0]] = resp;
    mem_idr[wr_ptr[5:0]]  = {is_wr, flag, id};
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic tick();
    @(negedge aclk);
  endtask

  int p0;

  initial begin
    aresetn  = 1'b0;
    bready   = 1'b0;
    rready   = 1'b0;
    stat_clr = 1'b0;
    for (int i = 0; i < 64; i++) begin
      mem_data[i] = '0;
      mem_resp[i] = '0;
      mem_idr[i]  = '0;
    end
    // Non-empty FIFO during reset.
    push(1'b1, 1'b1, 8'h55, 2'b00, 64'h0);

    // 1. Reset
    for (int i = 0; i < 2; i++) begin
      tick();
      check_eq("rst_r_en", {61'h0, rdata_r_en, resp_r_en, id_resp_r_en}, 64'h0);
    end
    check_eq("rst_bvalid", bvalid, 0);
    check_eq("rst_rvalid", rvalid, 0);
    check_eq("rst_rdata", rdata, 0);
    check_eq("rst_bid", bid, 0);
    check_eq("rst_cnts", {b_cnt, r_beat_cnt, drop_cnt}, 0);
    check_eq("rst_no_pop", pop_cnt, 0);
    aresetn = 1'b1;
    #1;
    check_eq("r_en_after_rst", {61'h0, rdata_r_en, resp_r_en, id_resp_r_en}, 64'h7);
    tick();
    check_eq("pre_bvalid", bvalid, 1);
    check_eq("pre_bid", bid, 8'h55);
    bready = 1'b1;
    tick();
    check_eq("pre_bdone", bvalid, 0);
    check_eq("pre_bid_clr", bid, 0);
    check_eq("pre_b_cnt", b_cnt, 1);
    bready   = 1'b0;
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    check_eq("clr_b_cnt", b_cnt, 0);

    // 2. Four back-to-back reads
    rready = 1'b1;
    for (int i = 0; i < 4; i++) push(1'b0, (i == 3), 8'h3A, 2'b00, 64'(i + 100));
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("rd_rvalid", rvalid, 1);
      check_eq("rd_rid", rid, 8'h3A);
      check_eq("rd_rdata", rdata, 64'(i + 100));
      check_eq("rd_rlast", rlast, (i == 3));
    end
    tick();
    check_eq("rd_rvalid_end", rvalid, 0);
    check_eq("rd_beat_cnt", r_beat_cnt, 4);

    // 3. Stall hold, read head waiting behind
    rready = 1'b0;
    push(1'b0, 1'b1, 8'h21, 2'b01, 64'hDEADBEEF_CAFEF00D);
    push(1'b0, 1'b0, 8'h22, 2'b00, 64'h2222);
    tick();
    p0 = pop_cnt;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("stall_rdata", rdata, 64'hDEADBEEF_CAFEF00D);
      check_eq("stall_rid_resp_last", {rid, rresp, rlast, rvalid}, {8'h21, 2'b01, 1'b1, 1'b1});
      check_eq("stall_r_en", rdata_r_en, 0);
    end
    check_eq("stall_no_pop", pop_cnt, p0);
    rready = 1'b1;
    tick();
    rready = 1'b0;
    check_eq("stall_next_rid", rid, 8'h22);
    check_eq("stall_next_rvalid", rvalid, 1);

    // 4. Stall isolation: write passes the stalled R channel
    push(1'b1, 1'b1, 8'h11, 2'b10, 64'h0);
    push(1'b0, 1'b0, 8'h33, 2'b00, 64'h3333);
    tick();
    check_eq("iso_bvalid", bvalid, 1);
    check_eq("iso_bresp", bresp, 2'b10);
    check_eq("iso_bid", bid, 8'h11);
    check_eq("iso_rid_held", rid, 8'h22);
    p0 = pop_cnt;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_eq("iso_read_blocked", rdata_r_en, 0);
    end
    check_eq("iso_no_pop", pop_cnt, p0);
    rready = 1'b1;
    tick();
    check_eq("iso_read_loaded", {rid, 7'h0, rvalid}, {8'h33, 8'h01});
    bready = 1'b1;
    tick();
    check_eq("iso_drained", {bvalid, rvalid}, 0);
    check_eq("iso_b_cnt", b_cnt, 1);
    check_eq("iso_r_beat_cnt", r_beat_cnt, 7);

    // 5. Discard of suppressed write
    push(1'b1, 1'b0, 8'h44, 2'b00, 64'h0);
    tick();
    check_eq("drop_bvalid", bvalid, 0);
    check_eq("drop_bid", bid, 0);
    check_eq("drop_cnt", drop_cnt, 1);
    check_eq("drop_popped", fifo_empty, 1);

    // 6. Saturation: 14 more back-to-back B beats bring b_cnt to 15
    for (int i = 0; i < 14; i++) push(1'b1, 1'b1, 8'(i), 2'b00, 64'h0);
    for (int i = 0; i < 14; i++) begin
      tick();
      check_eq("b2b_bvalid", bvalid, 1);
      check_eq("b2b_bid", bid, 8'(i));
    end
    tick();
    check_eq("sat_b_cnt_15", b_cnt, 15);
    check_eq("sat_bvalid_end", bvalid, 0);
    push(1'b1, 1'b1, 8'h77, 2'b11, 64'h0);
    tick();
    check_eq("sat_bvalid", bvalid, 1);
    tick();
    check_eq("sat_b_cnt_hold", b_cnt, 15);
    push(1'b1, 1'b1, 8'h78, 2'b00, 64'h0);
    tick();
    check_eq("clr_bvalid", bvalid, 1);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    check_eq("clr_prio_b_cnt", b_cnt, 0);
    check_eq("clr_other_cnts", {r_beat_cnt, drop_cnt}, 0);
    check_eq("clr_bvalid_end", bvalid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
